// File: rtl/captura_teclas_onehot.sv
// -----------------------------------------------------------------------------
// captura_teclas_onehot
//
// Input stage for the 7-input one-hot encoder. Seven raw push-buttons are
// synchronised, debounced as a single vector, and then checked so that only
// a single-key press reaches the encoder. Multi-key presses are flagged as an
// error instead.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset
//   btn      in   7  raw buttons, active-high, btn[6]=A ... btn[0]=G
//   clr      in   1  synchronous clear of sel
//   sel      out  7  registered one-hot selection for encoder inputs A..G
//   valid    out  1  one-cycle pulse when a new single-key press is accepted
//   pressed  out  1  high while the accepted key is still held
//   err      out  1  high while a multi-key condition is active
//   count    out  8  accepted-press counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module captura_teclas_onehot #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] btn,
    input  logic       clr,
    output logic [6:0] sel,
    output logic       valid,
    output logic       pressed,
    output logic       err,
    output logic [7:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Synchroniser and debounce state
    logic [6:0]       s1_q, s_q;
    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       deb_q, deb_d;

    // FSM state and registered outputs
    state_e           state_q, state_d;
    logic [6:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [7:0]       count_q, count_d;

    logic             deb_zero, deb_onehot;

    // -------------------------------------------------------------------------
    // Debounce next-state. The counter runs while the synchronised sample
    // matches the candidate; any change restarts it. Once it saturates at
    // DEB_CYCLES-1 the candidate is copied to deb on every edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (s_q != cand_q) begin
            cand_d = s_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d  = cand_q;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    assign deb_zero   = (deb_q == 7'd0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign deb_onehot = !deb_zero && ((deb_q & (deb_q - 7'd1)) == 7'd0);

    // -------------------------------------------------------------------------
    // FSM state register plus all other sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_q    <= '0;
            s_q     <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            s1_q    <= btn;
            s_q     <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (deb_onehot)     state_d = PRESS;
                else if (!deb_zero) state_d = FAULT;
            end
            PRESS: begin
                // A key swap without passing through zero is treated as a
                // multi-key event, so the encoder never sees an unannounced
                // selection change.
                if (deb_zero)            state_d = IDLE;
                else if (deb_q != sel_q) state_d = FAULT;
            end
            FAULT: begin
                if (deb_zero)       state_d = IDLE;
            end
            default:                state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM output logic (registered next values)
    // -------------------------------------------------------------------------
    always_comb begin
        sel_d   = clr ? 7'd0 : sel_q;
        valid_d = 1'b0;
        count_d = count_q;
        // Acceptance overrides a coincident clr.
        if (state_q == IDLE && deb_onehot) begin
            sel_d   = deb_q;
            valid_d = 1'b1;
            count_d = count_q + 8'd1;
        end
    end

    assign sel     = sel_q;
    assign valid   = valid_q;
    assign count   = count_q;
    assign pressed = (state_q == PRESS);
    assign err     = (state_q == FAULT);

endmodule

// File: tb/tb_captura_teclas_onehot.sv
// -----------------------------------------------------------------------------
// tb_captura_teclas_onehot
//
// Directed bench for captura_teclas_onehot with DEB_CYCLES=4. A clean edge
// applied before edge k shows up as valid/sel after edge k+7, i.e. after the
// 8th tick following the input change.
// -----------------------------------------------------------------------------
module tb_captura_teclas_onehot;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] btn;
    logic       clr;
    logic [6:0] sel;
    logic       valid;
    logic       pressed;
    logic       err;
    logic [7:0] count;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;        // valid pulses seen
    logic prev_valid = 1'b0;
    logic dbl_valid  = 1'b0; // set if valid was ever high two cycles in a row

    captura_teclas_onehot #(
        .DEB_CYCLES(4),
        .CNT_W     (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .clr    (clr),
        .sel    (sel),
        .valid  (valid),
        .pressed(pressed),
        .err    (err),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (valid) begin
            vcnt++;
            if (prev_valid) dbl_valid = 1'b1;
        end
        prev_valid = valid;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int v0;

    initial begin
        rst = 1'b1;
        btn = 7'h7F;
        clr = 1'b0;

        // ---------------- Reset ----------------
        ticks(3);
        check("rst_sel",     32'(sel),     32'h0);
        check("rst_valid",   32'(valid),   32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        check("rst_err",     32'(err),     32'h0);
        check("rst_count",   32'(count),   32'h0);

        // Release reset with all keys still held -> FAULT
        rst = 1'b0;
        ticks(7);
        check("allkeys_err_early", 32'(err), 32'h0);
        tick();
        check("allkeys_err",   32'(err),   32'h1);
        check("allkeys_sel",   32'(sel),   32'h0);
        check("allkeys_vcnt",  32'(vcnt),  32'h0);
        btn = 7'h00;
        ticks(10);
        check("allkeys_release_err", 32'(err), 32'h0);

        // ---------------- Clean press of C ----------------
        btn = 7'b0010000;
        ticks(7);
        check("c_valid_before", 32'(valid), 32'h0);
        tick();
        check("c_valid",   32'(valid),   32'h1);
        check("c_sel",     32'(sel),     32'h10);
        check("c_pressed", 32'(pressed), 32'h1);
        check("c_count",   32'(count),   32'h1);
        tick();
        check("c_valid_after", 32'(valid), 32'h0);
        ticks(11);
        btn = 7'h00;
        ticks(7);
        check("c_release_pressed_early", 32'(pressed), 32'h1);
        tick();
        check("c_release_pressed", 32'(pressed), 32'h0);
        check("c_release_sel",     32'(sel),     32'h10);

        // ---------------- Bounce on G ----------------
        ticks(5);
        v0 = vcnt;
        btn = 7'b0000001; tick(); tick();
        btn = 7'b0000000; tick();
        btn = 7'b0000001; tick();
        btn = 7'b0000000; tick(); tick();
        btn = 7'b0000001;
        ticks(15);
        check("bounce_vcnt",  32'(vcnt - v0), 32'h1);
        check("bounce_sel",   32'(sel),       32'h01);
        check("bounce_count", 32'(count),     32'h2);
        btn = 7'h00;
        ticks(10);

        // ---------------- Glitch rejection on D ----------------
        v0 = vcnt;
        btn = 7'b0001000;
        ticks(3);
        btn = 7'h00;
        ticks(12);
        check("glitch_vcnt",  32'(vcnt - v0), 32'h0);
        check("glitch_sel",   32'(sel),       32'h01);
        check("glitch_count", 32'(count),     32'h2);
        check("glitch_err",   32'(err),       32'h0);

        // ---------------- Multi-key ----------------
        btn = 7'b1000000;
        ticks(12);
        check("a_sel",   32'(sel),   32'h40);
        check("a_count", 32'(count), 32'h3);
        v0 = vcnt;
        btn = 7'b1100000;
        ticks(10);
        check("ab_err",     32'(err),       32'h1);
        check("ab_pressed", 32'(pressed),   32'h0);
        check("ab_vcnt",    32'(vcnt - v0), 32'h0);
        check("ab_sel",     32'(sel),       32'h40);
        check("ab_count",   32'(count),     32'h3);
        btn = 7'h00;
        ticks(10);
        check("ab_release_err",     32'(err),     32'h0);
        check("ab_release_pressed", 32'(pressed), 32'h0);
        btn = 7'b0100000;
        ticks(12);
        check("b_sel",     32'(sel),       32'h20);
        check("b_count",   32'(count),     32'h4);
        check("b_vcnt",    32'(vcnt - v0), 32'h1);
        btn = 7'h00;
        ticks(10);

        // ---------------- Counter wrap ----------------
        for (int i = 0; i < 251; i++) begin
            btn = (i % 2 == 0) ? 7'b0000001 : 7'b0000010;
            ticks(12);
            btn = 7'h00;
            ticks(10);
        end
        check("wrap_count_255", 32'(count), 32'hFF);
        btn = 7'b0000100;
        ticks(12);
        btn = 7'h00;
        ticks(10);
        check("wrap_count_0", 32'(count), 32'h0);
        check("wrap_sel",     32'(sel),   32'h04);

        // ---------------- clr while idle ----------------
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_idle_sel",   32'(sel),   32'h0);
        check("clr_idle_count", 32'(count), 32'h0);
        check("clr_idle_err",   32'(err),   32'h0);
        ticks(3);

        // ---------------- clr coinciding with acceptance ----------------
        btn = 7'b0000010;
        ticks(7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_accept_valid", 32'(valid), 32'h1);
        check("clr_accept_sel",   32'(sel),   32'h02);
        check("clr_accept_count", 32'(count), 32'h1);

        // clr during PRESS: sel cleared, state kept
        ticks(2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_press_sel",     32'(sel),     32'h0);
        check("clr_press_pressed", 32'(pressed), 32'h1);
        btn = 7'h00;
        ticks(10);

        // ---------------- Reset mid-press ----------------
        btn = 7'b0001000;
        ticks(9);
        rst = 1'b1;
        tick();
        check("midrst_sel",   32'(sel),   32'h0);
        check("midrst_count", 32'(count), 32'h0);
        rst = 1'b0;
        ticks(7);
        check("midrst_valid_before", 32'(valid), 32'h0);
        tick();
        check("midrst_valid", 32'(valid), 32'h1);
        check("midrst_sel2",  32'(sel),   32'h08);
        check("midrst_count2", 32'(count), 32'h1);
        btn = 7'h00;
        ticks(10);

        check("no_back_to_back_valid", 32'(dbl_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
